inst_memory_ctrl: RTL

Parametrised, loadable instruction memory with a handshaked fetch port. This is the next generation of the fixed 8x8 registered-read instruction ROM. A loader streams a program in over a serial write port. The CPU fetch stage then reads instructions through a valid/ready interface with a registered output and backpressure. Addresses beyond the loaded program length are flagged rather than returning stale data.

---
 rtl/inst_memory_ctrl_if.sv | 32 +++
 rtl/inst_memory_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/inst_memory_ctrl_if.sv
// Load and fetch bus of the instruction memory controller.
// The master side is the loader/CPU fetch stage; the slave side is the memory.
interface inst_memory_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic              inst_oob;
    logic              inst_ready;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_valid, fetch_addr, inst_ready,
        input  load_done, load_count, fetch_ready, inst_valid, inst, inst_oob
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_valid, fetch_addr, inst_ready,
        output load_done, load_count, fetch_ready, inst_valid, inst, inst_oob
    );
endinterface

// File: rtl/inst_memory_ctrl.sv
// Loadable instruction memory: serial program load, then valid/ready fetch
// with a registered output stage; reads past the program length are flagged.
module inst_memory_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               rst,
    inst_memory_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {EMPTY, LOADING, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              wr_en;
    logic              wr_end;
    logic              load_done;
    logic              fetch_ready;
    logic              accept;
    logic              in_range;
    logic              vld_p1;
    logic              oob_p1;
    logic [DATA_W-1:0] inst_p1;

    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        wr_end      = 1'b0;
        load_done   = 1'b0;
        fetch_ready = 1'b0;
        case (state_q)
            EMPTY: begin
                if (bus.load_start) state_d = LOADING;
            end
            LOADING: begin
                // A restart wins over a write in the same cycle; its data is dropped.
                if (!bus.load_start && bus.load_valid) begin
                    wr_en  = 1'b1;
                    wr_end = bus.load_last || (wr_ptr_q == ADDR_W'(DEPTH - 1));
                    if (wr_end) state_d = RUN;
                end
            end
            RUN: begin
                load_done = 1'b1;
                if (bus.load_start) state_d = LOADING;
                else                fetch_ready = !vld_p1 || bus.inst_ready;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign accept   = bus.fetch_valid && fetch_ready;
    assign in_range = {1'b0, bus.fetch_addr} < count_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.load_start) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= {1'b0, wr_ptr_q} + 1'b1;
            end
        end
    end

    // p1: fetch output register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            inst_p1 <= '0;
            oob_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            inst_p1 <= in_range ? mem[bus.fetch_addr] : '0;
            oob_p1  <= !in_range;
        end else if (bus.load_start || bus.inst_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.load_done   = load_done;
    assign bus.load_count  = count_q;
    assign bus.fetch_ready = fetch_ready;
    assign bus.inst_valid  = vld_p1;
    assign bus.inst        = inst_p1;
    assign bus.inst_oob    = oob_p1;
endmodule
